// File: rtl/mem_port_arbiter.sv
// Arbitrates one core-side memory port between IFU fetches and LSU loads/stores, one transaction in flight.
// Define MEM_ARB_RR_EN for round-robin arbitration; the default build gives the LSU fixed priority.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0] ifu_req_addr,
    output logic                  ifu_resp_valid,
    output logic [DATA_WIDTH-1:0] ifu_resp_rdata,
    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_req_addr,
    input  logic                  lsu_req_wen,
    input  logic [DATA_WIDTH-1:0] lsu_req_wdata,
    input  logic [STRB_WIDTH-1:0] lsu_req_wmask,
    output logic                  lsu_resp_valid,
    output logic [DATA_WIDTH-1:0] lsu_resp_rdata,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic                  mem_req_wen,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    output logic [STRB_WIDTH-1:0] mem_req_wmask,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_rdata,
    output logic                  arb_busy
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

    state_e                state_q, state_d;
    logic                  owner_q, owner_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wen_q, wen_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wmask_q, wmask_d;
    logic                  ifu_resp_valid_q, ifu_resp_valid_d;
    logic [DATA_WIDTH-1:0] ifu_resp_rdata_q, ifu_resp_rdata_d;
    logic                  lsu_resp_valid_q, lsu_resp_valid_d;
    logic [DATA_WIDTH-1:0] lsu_resp_rdata_q, lsu_resp_rdata_d;
    logic                  lsu_wins;
    logic                  complete;
`ifdef MEM_ARB_RR_EN
    logic                  last_grant_q, last_grant_d;

    // On contention the requester not granted last time wins; 0 = IFU, 1 = LSU.
    assign lsu_wins = lsu_req_valid && (!ifu_req_valid || !last_grant_q);
`else
    assign lsu_wins = lsu_req_valid;
`endif

    // Readies are forced low during reset so no handshake is lost to it.
    assign lsu_req_ready = (state_q == IDLE) && !rst && lsu_wins;
    assign ifu_req_ready = (state_q == IDLE) && !rst && ifu_req_valid && !lsu_wins;

    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        addr_d           = addr_q;
        wen_d            = wen_q;
        wdata_d          = wdata_q;
        wmask_d          = wmask_q;
        ifu_resp_valid_d = 1'b0;
        ifu_resp_rdata_d = ifu_resp_rdata_q;
        lsu_resp_valid_d = 1'b0;
        lsu_resp_rdata_d = lsu_resp_rdata_q;
        complete         = 1'b0;
`ifdef MEM_ARB_RR_EN
        last_grant_d     = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (ifu_req_ready || lsu_req_ready) begin
                    owner_d = lsu_req_ready;
                    addr_d  = lsu_req_ready ? lsu_req_addr  : ifu_req_addr;
                    wen_d   = lsu_req_ready && lsu_req_wen;
                    wdata_d = lsu_req_ready ? lsu_req_wdata : '0;
                    wmask_d = lsu_req_ready ? lsu_req_wmask : '0;
                    state_d = REQ;
`ifdef MEM_ARB_RR_EN
                    last_grant_d = lsu_req_ready;
`endif
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    complete = mem_resp_valid;
                    state_d  = mem_resp_valid ? IDLE : RESP;
                end
            end
            RESP: begin
                if (mem_resp_valid) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (complete) begin
            if (owner_q) begin
                lsu_resp_valid_d = 1'b1;
                lsu_resp_rdata_d = mem_resp_rdata;
            end else begin
                ifu_resp_valid_d = 1'b1;
                ifu_resp_rdata_d = mem_resp_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            owner_q          <= 1'b0;
            addr_q           <= '0;
            wen_q            <= 1'b0;
            wdata_q          <= '0;
            wmask_q          <= '0;
            ifu_resp_valid_q <= 1'b0;
            ifu_resp_rdata_q <= '0;
            lsu_resp_valid_q <= 1'b0;
            lsu_resp_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
            last_grant_q     <= 1'b0;
`endif
        end else begin
            state_q          <= state_d;
            owner_q          <= owner_d;
            addr_q           <= addr_d;
            wen_q            <= wen_d;
            wdata_q          <= wdata_d;
            wmask_q          <= wmask_d;
            ifu_resp_valid_q <= ifu_resp_valid_d;
            ifu_resp_rdata_q <= ifu_resp_rdata_d;
            lsu_resp_valid_q <= lsu_resp_valid_d;
            lsu_resp_rdata_q <= lsu_resp_rdata_d;
`ifdef MEM_ARB_RR_EN
            last_grant_q     <= last_grant_d;
`endif
        end
    end

    assign mem_req_valid  = (state_q == REQ);
    assign mem_req_addr   = addr_q;
    assign mem_req_wen    = wen_q;
    assign mem_req_wdata  = wdata_q;
    assign mem_req_wmask  = wmask_q;
    assign arb_busy       = (state_q != IDLE);
    assign ifu_resp_valid = ifu_resp_valid_q;
    assign ifu_resp_rdata = ifu_resp_rdata_q;
    assign lsu_resp_valid = lsu_resp_valid_q;
    assign lsu_resp_rdata = lsu_resp_rdata_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single core-side memory port between instruction fetch (IFU) and load/store (LSU).
- Each requester has a valid/ready request channel and a response pulse.
- The downstream port has a valid/ready request channel and a variable-latency response.
- At most one transaction is outstanding at any time.
- Sits between IFU/MEMU and the memory/bus adapter; replaces the direct DataMemCtrl-to-memory path once fetch and data share one port.

Parameters:
ADDR_WIDTH, 32, address width of all request channels
DATA_WIDTH, 32, data width; must be a multiple of 8
STRB_WIDTH, DATA_WIDTH/8, byte write-mask width (derived)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
ifu_req_valid  in  1  IFU read request
ifu_req_ready  out  1  IFU request accepted this cycle
ifu_req_addr  in  ADDR_WIDTH  fetch address
ifu_resp_valid  out  1  one-cycle pulse; fetch data valid
ifu_resp_rdata  out  DATA_WIDTH  fetch data
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_req_addr  in  ADDR_WIDTH  load/store address
lsu_req_wen  in  1  1 = store, 0 = load
lsu_req_wdata  in  DATA_WIDTH  store data
lsu_req_wmask  in  STRB_WIDTH  store byte mask
lsu_resp_valid  out  1  one-cycle pulse; load data valid or store acknowledged
lsu_resp_rdata  out  DATA_WIDTH  load data (don't-care for stores)
mem_req_valid  out  1  downstream request valid
mem_req_ready  in  1  downstream request accepted
mem_req_addr  out  ADDR_WIDTH  registered address
mem_req_wen  out  1  registered write enable
mem_req_wdata  out  DATA_WIDTH  registered write data
mem_req_wmask  out  STRB_WIDTH  registered mask; 0 for IFU requests
mem_resp_valid  in  1  downstream response valid (reads and writes)
mem_resp_rdata  in  DATA_WIDTH  downstream read data
arb_busy  out  1  state != IDLE

Behaviour:
- State machine: IDLE, REQ, RESP; reset state IDLE. Owner register: 0 = IFU, 1 = LSU.
- Reset values: all outputs 0; mem_req_* registers 0; owner 0.
- Reset mid-transaction: return to IDLE; pending transaction is dropped and no resp pulse is issued. A mem_resp_valid received in IDLE is ignored.
- IDLE:
  - The winner's *_req_ready = 1, combinationally from the valids. The loser's ready and both readies outside IDLE are 0.
  - Without MEM_ARB_RR_EN, LSU has fixed priority over IFU.
  - On handshake: latch addr, wen, wdata and wmask (IFU: wen = 0, wmask = 0, wdata = 0), latch owner, then go to REQ.
- REQ:
  - mem_req_valid = 1 with the registered fields, held stable until mem_req_ready.
  - On mem_req_ready, go to RESP.
  - If mem_resp_valid is also high in the same cycle, complete the transaction as in RESP and go directly to IDLE.
  - mem_resp_valid without mem_req_ready in REQ is ignored.
- RESP:
  - mem_req_valid = 0; wait for mem_resp_valid.
  - On mem_resp_valid: register rdata into the owner's *_resp_rdata, pulse the owner's *_resp_valid the following cycle for exactly 1 cycle, and go to IDLE.
  - The non-owner's resp_valid stays 0.
- Response outputs are registered. *_resp_rdata holds its last value until the next response to that requester.
- Earliest back-to-back operation: a new request is accepted in the same cycle the previous resp pulse is visible, because the FSM is already in IDLE.
- Minimum latency, request handshake to resp pulse: 2 cycles, with mem_req_ready = 1 and a same-cycle response.
- Requesters must hold a request stable until ready. Requesters always accept responses; there is no response backpressure.

Optional Feature:
MEM_ARB_RR_EN
- Defined: round-robin arbitration. A last_grant register (reset = IFU) is updated on every request handshake. When both requesters are valid in IDLE, the one not granted last wins; a single valid requester always wins.
- Undefined: fixed LSU priority; no last_grant register.

Test Plan:
1. IFU-only read: ifu_req_valid, addr 0x8000_0000; mem_req_ready = 1; mem_resp_valid 3 cycles later with rdata 0x0000_0413 -> mem_req_addr = 0x8000_0000, wen = 0, wmask = 0; ifu_resp_valid pulses 1 cycle with rdata 0x0000_0413; lsu_resp_valid stays 0.
2. LSU store: addr 0x8000_1004, wdata 0xDEAD_BEEF, wmask 0xF; mem_req_ready delayed 2 cycles -> mem_req_valid and fields stable for 3 cycles; lsu_resp_valid pulses once after mem_resp_valid.
3. Simultaneous IFU and LSU requests, repeated 4 times -> fixed mode: LSU granted first each time, IFU served after each LSU response. MEM_ARB_RR_EN: grants alternate LSU, IFU, LSU, IFU.
4. Zero-latency memory: mem_req_ready and mem_resp_valid high in the same REQ cycle -> FSM REQ->IDLE; resp pulse 2 cycles after the request handshake; back-to-back IFU reads 0x0, 0x4, 0x8 complete in order.
5. rst asserted during RESP of an LSU load, then mem_resp_valid arrives -> no lsu_resp_valid; arb_busy = 0; all mem_req_* = 0; next IFU request is served normally.
